// File: rtl/global_buffer_param.sv
// Shared AXI4-lite constants and the config-master state encoding.
package global_buffer_param;

  localparam int CGRA_AXI_ADDR_WIDTH = 12;
  localparam int CGRA_AXI_DATA_WIDTH = 32;

  localparam logic [1:0] AXI_RESP_OKAY = 2'b00;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WR,
    ST_B,
    ST_AR,
    ST_R,
    ST_RSP
  } axil_cfg_state_e;

  function automatic logic axi_resp_err(input logic [1:0] resp);
    return resp != AXI_RESP_OKAY;
  endfunction

endpackage

// File: rtl/axil_cfg_master_if.sv
// Command/response port plus AXI4-lite master signals; master = the bridge, slave = its environment.
interface axil_cfg_master_if #(
  parameter int ADDR_WIDTH = global_buffer_param::CGRA_AXI_ADDR_WIDTH,
  parameter int DATA_WIDTH = global_buffer_param::CGRA_AXI_DATA_WIDTH
);
  logic                  req_valid;
  logic                  req_ready;
  logic                  req_write;
  logic [ADDR_WIDTH-1:0] req_addr;
  logic [DATA_WIDTH-1:0] req_data;

  logic                  rsp_valid;
  logic                  rsp_ready;
  logic [DATA_WIDTH-1:0] rsp_data;
  logic                  rsp_err;

  logic [ADDR_WIDTH-1:0] awaddr;
  logic                  awvalid;
  logic                  awready;
  logic [DATA_WIDTH-1:0] wdata;
  logic                  wvalid;
  logic                  wready;
  logic [1:0]            bresp;
  logic                  bvalid;
  logic                  bready;
  logic [ADDR_WIDTH-1:0] araddr;
  logic                  arvalid;
  logic                  arready;
  logic [DATA_WIDTH-1:0] rdata;
  logic [1:0]            rresp;
  logic                  rvalid;
  logic                  rready;

  modport master (
    input  req_valid, req_write, req_addr, req_data, rsp_ready,
           awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid,
    output req_ready, rsp_valid, rsp_data, rsp_err,
           awaddr, awvalid, wdata, wvalid, bready, araddr, arvalid, rready
  );

  modport slave (
    output req_valid, req_write, req_addr, req_data, rsp_ready,
           awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid,
    input  req_ready, rsp_valid, rsp_data, rsp_err,
           awaddr, awvalid, wdata, wvalid, bready, araddr, arvalid, rready
  );

endinterface

// File: rtl/axil_cfg_master.sv
// Single-outstanding AXI4-lite master turning config commands into one write or read each.
// IDLE accept | WR aw+w | B wait bresp | AR address | R wait rdata | RSP hold response
module axil_cfg_master
  import global_buffer_param::*;
#(
  parameter int ADDR_WIDTH = CGRA_AXI_ADDR_WIDTH,
  parameter int DATA_WIDTH = CGRA_AXI_DATA_WIDTH,
  parameter int TIMEOUT    = 256
) (
  input  logic              clk,
  input  logic              reset,
  axil_cfg_master_if.master bus
);

  localparam int              CNT_W    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  axil_cfg_state_e       r_state;
  logic                  r_req_ready;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [DATA_WIDTH-1:0] r_data;
  logic                  r_awvalid;
  logic                  r_wvalid;
  logic                  r_arvalid;
  logic                  r_bready;
  logic                  r_rready;
  logic                  r_rsp_valid;
  logic [DATA_WIDTH-1:0] r_rsp_data;
  logic                  r_rsp_err;
  logic [CNT_W-1:0]      r_cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= ST_IDLE;
      r_req_ready <= 1'b0;
      r_addr      <= '0;
      r_data      <= '0;
      r_awvalid   <= 1'b0;
      r_wvalid    <= 1'b0;
      r_arvalid   <= 1'b0;
      r_bready    <= 1'b0;
      r_rready    <= 1'b0;
      r_rsp_valid <= 1'b0;
      r_rsp_data  <= '0;
      r_rsp_err   <= 1'b0;
      r_cnt       <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_req_ready <= 1'b1;
          if (bus.req_valid && r_req_ready) begin
            r_req_ready <= 1'b0;
            r_addr      <= bus.req_addr;
            r_data      <= bus.req_data;
            if (bus.req_write) begin
              r_awvalid <= 1'b1;
              r_wvalid  <= 1'b1;
              r_state   <= ST_WR;
            end else begin
              r_arvalid <= 1'b1;
              r_state   <= ST_AR;
            end
          end
        end

        ST_WR: begin
          if (bus.awready) r_awvalid <= 1'b0;
          if (bus.wready)  r_wvalid  <= 1'b0;
          // AW and W may complete in either order or together
          if ((!r_awvalid || bus.awready) && (!r_wvalid || bus.wready)) begin
            r_bready <= 1'b1;
            r_cnt    <= '0;
            r_state  <= ST_B;
          end
        end

        ST_B: begin
          if (bus.bvalid) begin
            r_bready    <= 1'b0;
            r_rsp_valid <= 1'b1;
            r_rsp_data  <= '0;
            r_rsp_err   <= axi_resp_err(bus.bresp);
            r_state     <= ST_RSP;
          end else if (r_cnt == CNT_LAST) begin
            r_bready    <= 1'b0;
            r_rsp_valid <= 1'b1;
            r_rsp_data  <= '0;
            r_rsp_err   <= 1'b1;
            r_state     <= ST_RSP;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end

        ST_AR: begin
          if (bus.arready) begin
            r_arvalid <= 1'b0;
            r_rready  <= 1'b1;
            r_cnt     <= '0;
            r_state   <= ST_R;
          end
        end

        ST_R: begin
          if (bus.rvalid) begin
            r_rready    <= 1'b0;
            r_rsp_valid <= 1'b1;
            r_rsp_data  <= axi_resp_err(bus.rresp) ? '0 : bus.rdata;
            r_rsp_err   <= axi_resp_err(bus.rresp);
            r_state     <= ST_RSP;
          end else if (r_cnt == CNT_LAST) begin
            r_rready    <= 1'b0;
            r_rsp_valid <= 1'b1;
            r_rsp_data  <= '0;
            r_rsp_err   <= 1'b1;
            r_state     <= ST_RSP;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end

        ST_RSP: begin
          if (bus.rsp_ready) begin
            r_rsp_valid <= 1'b0;
            r_rsp_data  <= '0;
            r_rsp_err   <= 1'b0;
            r_req_ready <= 1'b1;
            r_state     <= ST_IDLE;
          end
        end

        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.req_ready = r_req_ready;
  assign bus.awaddr    = r_addr;
  assign bus.awvalid   = r_awvalid;
  assign bus.wdata     = r_data;
  assign bus.wvalid    = r_wvalid;
  assign bus.bready    = r_bready;
  assign bus.araddr    = r_addr;
  assign bus.arvalid   = r_arvalid;
  assign bus.rready    = r_rready;
  assign bus.rsp_valid = r_rsp_valid;
  assign bus.rsp_data  = r_rsp_data;
  assign bus.rsp_err   = r_rsp_err;

endmodule

// File: tb/tb_axil_cfg_master.sv
// Directed bench: scripted AXI-lite slave, response scoreboard, handshake/timing traces.
module tb_axil_cfg_master;
  import global_buffer_param::*;

  localparam int AW = CGRA_AXI_ADDR_WIDTH;
  localparam int DW = CGRA_AXI_DATA_WIDTH;
  localparam int TO = 8;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  axil_cfg_master_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

  axil_cfg_master #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT(TO)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [DW-1:0] data;
    logic          err;
  } rsp_t;
  rsp_t exp_q[$];
  int   rsp_seen = 0;

  // slave behaviour knobs, changed only while the DUT is idle
  int            aw_dly = 0, w_dly = 0, ar_dly = 0, b_dly = 0, r_dly = 0;
  bit            r_never = 1'b0;
  logic [1:0]    bresp_cfg = 2'b00, rresp_cfg = 2'b00;
  logic [DW-1:0] rdata_cfg = '0;
  logic [AW-1:0] exp_addr = '0;
  logic [DW-1:0] exp_wdata = '0;

  bit clr_trace = 1'b0;
  int aw_vld_n, w_vld_n, ar_vld_n, rready_n, aw_hs_n, w_hs_n;
  int addr_bad, wdata_bad, aw_hs_cyc, w_hs_cyc, first_rsp_cyc;

  task automatic check(input string name, input longint act, input longint exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // scripted slave: decides readies/responses at the falling edge
  initial begin
    bit aw_hs, w_hs, ar_hs, b_hs, r_hs, aw_done, w_done, b_arm, r_arm;
    int aw_c, w_c, ar_c, b_c, r_c;
    {aw_hs, w_hs, ar_hs, b_hs, r_hs, aw_done, w_done, b_arm, r_arm} = '0;
    {aw_c, w_c, ar_c, b_c, r_c} = '0;
    bus.awready = 1'b0; bus.wready = 1'b0; bus.arready = 1'b0;
    bus.bvalid = 1'b0; bus.bresp = 2'b00; bus.rvalid = 1'b0; bus.rresp = 2'b00; bus.rdata = '0;
    forever begin
      @(negedge clk);
      if (reset) begin
        {aw_hs, w_hs, ar_hs, b_hs, r_hs, aw_done, w_done, b_arm, r_arm} = '0;
        {aw_c, w_c, ar_c, b_c, r_c} = '0;
        bus.awready = 1'b0; bus.wready = 1'b0; bus.arready = 1'b0;
        bus.bvalid = 1'b0; bus.rvalid = 1'b0;
      end else begin
        if (clr_trace) begin
          {aw_vld_n, w_vld_n, ar_vld_n, rready_n, aw_hs_n, w_hs_n, addr_bad, wdata_bad} = '0;
          aw_hs_cyc = -1; w_hs_cyc = -1; first_rsp_cyc = -1;
          clr_trace = 1'b0;
        end
        if (b_hs) bus.bvalid = 1'b0;
        if (r_hs) bus.rvalid = 1'b0;
        if (aw_hs) aw_done = 1'b1;
        if (w_hs)  w_done = 1'b1;
        if (aw_done && w_done) begin aw_done = 1'b0; w_done = 1'b0; b_arm = 1'b1; b_c = 0; end
        if (ar_hs) begin r_arm = !r_never; r_c = 0; end
        if (b_arm) begin
          if (b_c >= b_dly) begin bus.bvalid = 1'b1; bus.bresp = bresp_cfg; b_arm = 1'b0; end
          else b_c++;
        end
        if (r_arm) begin
          if (r_c >= r_dly) begin
            bus.rvalid = 1'b1; bus.rresp = rresp_cfg; bus.rdata = rdata_cfg; r_arm = 1'b0;
          end else r_c++;
        end
        bus.awready = bus.awvalid && (aw_c >= aw_dly);
        bus.wready  = bus.wvalid  && (w_c  >= w_dly);
        bus.arready = bus.arvalid && (ar_c >= ar_dly);
        aw_hs = bus.awvalid && bus.awready;
        w_hs  = bus.wvalid  && bus.wready;
        ar_hs = bus.arvalid && bus.arready;
        b_hs  = bus.bvalid  && bus.bready;
        r_hs  = bus.rvalid  && bus.rready;
        aw_c = aw_hs ? 0 : (bus.awvalid ? aw_c + 1 : aw_c);
        w_c  = w_hs  ? 0 : (bus.wvalid  ? w_c + 1  : w_c);
        ar_c = ar_hs ? 0 : (bus.arvalid ? ar_c + 1 : ar_c);
        if (bus.awvalid) begin aw_vld_n++; if (bus.awaddr != exp_addr) addr_bad++; end
        if (bus.wvalid)  begin w_vld_n++;  if (bus.wdata != exp_wdata) wdata_bad++; end
        if (bus.arvalid) begin ar_vld_n++; if (bus.araddr != exp_addr) addr_bad++; end
        if (bus.rready) rready_n++;
        if (aw_hs) begin aw_hs_n++; aw_hs_cyc = cyc; end
        if (w_hs)  begin w_hs_n++;  w_hs_cyc = cyc; end
        if (bus.rsp_valid && first_rsp_cyc < 0) first_rsp_cyc = cyc;
      end
    end
  end

  // response monitor: every cycle a response is presented it must match the queue head
  initial begin
    forever begin
      @(negedge clk);
      if (!reset && bus.rsp_valid) begin
        if (exp_q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL rsp_unexpected: got data 0x%0h err %0b with nothing expected", bus.rsp_data, bus.rsp_err);
        end else begin
          check("rsp_data", bus.rsp_data, exp_q[0].data);
          check("rsp_err", bus.rsp_err, exp_q[0].err);
          if (bus.rsp_ready) begin
            void'(exp_q.pop_front());
            rsp_seen++;
          end
        end
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic issue(input bit wr, input logic [AW-1:0] a, input logic [DW-1:0] d, output int acc);
    int i;
    i = 0;
    while (!bus.req_ready && i < 100) begin @(negedge clk); i++; end
    check("req_ready_wait", bus.req_ready, 1);
    bus.req_valid = 1'b1;
    bus.req_write = wr;
    bus.req_addr  = a;
    bus.req_data  = d;
    acc = cyc + 1;
    @(negedge clk);
    bus.req_valid = 1'b0;
  endtask

  task automatic wait_rsp(input int target);
    int i;
    i = 0;
    while (rsp_seen < target && i < 200) begin @(negedge clk); i++; end
    check("rsp_done", rsp_seen, target);
    @(negedge clk);
  endtask

  task automatic expect_rsp(input logic [DW-1:0] d, input logic e);
    rsp_t r;
    r.data = d;
    r.err  = e;
    exp_q.push_back(r);
  endtask

  initial begin
    int acc, i;
    bus.req_valid = 1'b0; bus.req_write = 1'b0; bus.req_addr = '0; bus.req_data = '0;
    bus.rsp_ready = 1'b1;
    repeat (3) @(negedge clk);
    check("reset_outputs",
          {bus.awvalid, bus.wvalid, bus.arvalid, bus.bready, bus.rready,
           bus.rsp_valid, bus.rsp_err, bus.req_ready}, 0);
    check("reset_rsp_data", bus.rsp_data, 0);
    reset = 1'b0;
    @(negedge clk);
    check("req_ready_after_reset", bus.req_ready, 1);

    // write, zero-wait slave: rsp_valid lands in the third cycle after the accept edge
    aw_dly = 0; w_dly = 0; b_dly = 0; bresp_cfg = 2'b00;
    exp_addr = 12'h010; exp_wdata = 32'hDEADBEEF; clr_trace = 1'b1;
    expect_rsp(32'h0, 1'b0);
    issue(1'b1, 12'h010, 32'hDEADBEEF, acc);
    wait_rsp(1);
    check("wr_latency_cycles", first_rsp_cyc - acc + 1, 3);
    check("wr_aw_handshakes", aw_hs_n, 1);
    check("wr_w_handshakes", w_hs_n, 1);
    check("wr_addr_stable", addr_bad, 0);
    check("wr_data_stable", wdata_bad, 0);

    // read with arready four cycles late
    ar_dly = 4; r_dly = 0; rresp_cfg = 2'b00; rdata_cfg = 32'h12345678;
    exp_addr = 12'h020; clr_trace = 1'b1;
    expect_rsp(32'h12345678, 1'b0);
    issue(1'b0, 12'h020, 32'h0, acc);
    wait_rsp(2);
    check("rd_arvalid_cycles", ar_vld_n, 5);
    check("rd_addr_stable", addr_bad, 0);

    // W accepted two cycles before AW, error response
    ar_dly = 0; aw_dly = 2; w_dly = 0; bresp_cfg = 2'b10;
    exp_addr = 12'h024; exp_wdata = 32'h0BADF00D; clr_trace = 1'b1;
    expect_rsp(32'h0, 1'b1);
    issue(1'b1, 12'h024, 32'h0BADF00D, acc);
    wait_rsp(3);
    check("wfirst_wvalid_cycles", w_vld_n, 1);
    check("wfirst_awvalid_cycles", aw_vld_n, 3);
    check("wfirst_hs_gap", aw_hs_cyc - w_hs_cyc, 2);
    check("wfirst_addr_stable", addr_bad, 0);

    // read whose data never comes back
    aw_dly = 0; bresp_cfg = 2'b00; r_never = 1'b1;
    exp_addr = 12'h028; clr_trace = 1'b1;
    expect_rsp(32'h0, 1'b1);
    issue(1'b0, 12'h028, 32'h0, acc);
    wait_rsp(4);
    check("timeout_rready_cycles", rready_n, TO);
    check("timeout_back_to_idle", bus.req_ready, 1);
    r_never = 1'b0;

    // response held back for ten cycles
    bus.rsp_ready = 1'b0;
    exp_addr = 12'h030; exp_wdata = 32'hA5A50001; clr_trace = 1'b1;
    expect_rsp(32'h0, 1'b0);
    issue(1'b1, 12'h030, 32'hA5A50001, acc);
    i = 0;
    while (!bus.rsp_valid && i < 50) begin @(negedge clk); i++; end
    check("stall_rsp_arrives", bus.rsp_valid, 1);
    for (int k = 0; k < 10; k++) begin
      check("stall_rsp_valid_held", bus.rsp_valid, 1);
      check("stall_req_ready_low", bus.req_ready, 0);
      @(negedge clk);
    end
    @(posedge clk);
    #1 bus.rsp_ready = 1'b1;
    wait_rsp(5);

    // reset in the middle of a write
    aw_dly = 6; w_dly = 6;
    exp_addr = 12'h040; exp_wdata = 32'h11112222; clr_trace = 1'b1;
    issue(1'b1, 12'h040, 32'h11112222, acc);
    @(negedge clk);
    check("midwr_valids_up", {bus.awvalid, bus.wvalid}, 2'b11);
    #2 reset = 1'b1;
    #1 check("midwr_async_clear",
             {bus.awvalid, bus.wvalid, bus.arvalid, bus.bready, bus.rready,
              bus.rsp_valid, bus.rsp_err, bus.req_ready}, 0);
    repeat (2) @(negedge clk);
    check("midwr_req_ready_in_reset", bus.req_ready, 0);
    reset = 1'b0;
    aw_dly = 0; w_dly = 0;
    @(negedge clk);
    check("midwr_req_ready_after_release", bus.req_ready, 1);

    // recovery read after the aborted write
    rdata_cfg = 32'hCAFEF00D; exp_addr = 12'h044; clr_trace = 1'b1;
    expect_rsp(32'hCAFEF00D, 1'b0);
    issue(1'b0, 12'h044, 32'h0, acc);
    wait_rsp(6);
    check("recover_addr_stable", addr_bad, 0);
    check("queue_drained", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
